// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: opcodes, alu codes, class bit indices and shared types for the decode stage
package decode_stage_pkg;

    localparam logic [6:0] INST_R      = 7'b0110011;
    localparam logic [6:0] INST_I      = 7'b0010011;
    localparam logic [6:0] INST_U1     = 7'b0110111;
    localparam logic [6:0] INST_AUIPC  = 7'b0010111;
    localparam logic [6:0] INST_LOAD   = 7'b0000011;
    localparam logic [6:0] INST_STORE  = 7'b0100011;
    localparam logic [6:0] INST_BRANCH = 7'b1100011;
    localparam logic [6:0] INST_JAL    = 7'b1101111;
    localparam logic [6:0] INST_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_OP_ADD = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB = 4'b1000;

    localparam int CLS_R      = 0;
    localparam int CLS_I      = 1;
    localparam int CLS_LOAD   = 2;
    localparam int CLS_STORE  = 3;
    localparam int CLS_BRANCH = 4;
    localparam int CLS_JAL    = 5;
    localparam int CLS_JALR   = 6;
    localparam int CLS_LUI    = 7;
    localparam int CLS_AUIPC  = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b11
    } state_t;

    typedef struct packed {
        logic [8:0] cls;
        logic [3:0] alu_op;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/decode_stage_inst_decode.sv
// inst_decode_comb: combinational RV32I/RV64I instruction class, alu_op, immediate and legality decode
module inst_decode_comb
    import decode_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EN_SHAMT6 = 1'b0
) (
    input  logic [31:0]     inst,
    output logic [8:0]      cls,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [6:0] op;
    logic [6:0] f7;
    logic [5:0] f6;
    logic [2:0] f3;
    logic is_r, is_i, is_load, is_store, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic sh_zero, sh_ok;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign op = inst[6:0];
    assign f3 = inst[14:12];
    assign f7 = inst[31:25];
    assign f6 = inst[31:26];

    assign is_r     = op == INST_R;
    assign is_i     = op == INST_I;
    assign is_load  = op == INST_LOAD;
    assign is_store = op == INST_STORE;
    assign is_br    = op == INST_BRANCH;
    assign is_jal   = op == INST_JAL;
    assign is_jalr  = op == INST_JALR;
    assign is_lui   = op == INST_U1;
    assign is_auipc = op == INST_AUIPC;

    // RV64 shifts borrow inst[25] for shamt, so only the upper six bits act as funct
    assign sh_zero = EN_SHAMT6 ? f6 == 6'd0 : f7 == 7'd0;
    assign sh_ok   = sh_zero | (EN_SHAMT6 ? f6 == 6'b010000 : f7 == 7'b0100000);

    assign illegal = (inst[1:0] != 2'b11)
        | !(is_r | is_i | is_load | is_store | is_br | is_jal | is_jalr | is_lui | is_auipc)
        | (is_r & f7 != 7'd0 & f7 != 7'b0100000)
        | (is_r & f7 == 7'b0100000 & f3 != 3'b000 & f3 != 3'b101)
        | (is_i & f3 == 3'b001 & !sh_zero)
        | (is_i & f3 == 3'b101 & !sh_ok)
        | (is_load & (XLEN == 32 ? (f3 == 3'b011 | f3[2:1] == 2'b11) : f3 == 3'b111))
        | (is_store & f3 > (XLEN == 32 ? 3'd2 : 3'd3))
        | (is_br & f3[2:1] == 2'b01)
        | (is_jalr & f3 != 3'b000);

    assign imm_i = {{(XLEN-11){inst[31]}}, inst[30:20]};
    assign imm_s = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
    assign imm_b = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    assign cls = illegal ? '0 : {is_auipc, is_lui, is_jalr, is_jal, is_br, is_store, is_load, is_i, is_r};

    assign alu_op = illegal                        ? ALU_OP_ADD :
                    is_r | (is_i & f3 == 3'b101)   ? {f7[5], f3} :
                    is_i                           ? {1'b0, f3} :
                    is_br                          ? ALU_OP_SUB : ALU_OP_ADD;

    assign imm = is_i | is_load | is_jalr ? imm_i :
                 is_store                 ? imm_s :
                 is_br                    ? imm_b :
                 is_lui | is_auipc        ? imm_u :
                 is_jal                   ? imm_j : '0;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode with output + skid buffer and valid/ready on both sides
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EN_SHAMT6 = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [8:0]      out_class,
    output logic [3:0]      out_alu_op,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    logic [8:0]      d_cls;
    logic [3:0]      d_alu;
    logic [XLEN-1:0] d_imm;
    logic            d_ill;
    dec_t            in_dec, out_dec, skid_dec;
    logic [XLEN-1:0] out_pc_q, out_imm_q, skid_pc, skid_imm;
    state_t          state, nxt;
    logic            in_fire, out_fire, ld_out, ld_skid, use_skid;

    inst_decode_comb #(.XLEN(XLEN), .EN_SHAMT6(EN_SHAMT6)) u_dec (
        .inst    (in_inst),
        .cls     (d_cls),
        .alu_op  (d_alu),
        .imm     (d_imm),
        .illegal (d_ill)
    );

    assign in_dec = '{cls: d_cls, alu_op: d_alu, funct3: in_inst[14:12], rs1: in_inst[19:15],
                      rs2: in_inst[24:20], rd: in_inst[11:7], illegal: d_ill};

    // state bits are {skid_valid, out_valid}, so both handshake outputs come straight off flops
    assign out_valid = state[0];
    assign in_ready  = !state[1];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_EMPTY;
        else     state <= nxt;
    end

    always_comb begin
        nxt      = state;
        ld_out   = 1'b0;
        ld_skid  = 1'b0;
        use_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                nxt    = in_fire ? ST_FULL : ST_EMPTY;
                ld_out = in_fire;
            end
            ST_FULL: begin
                nxt     = in_fire & !out_fire ? ST_SKID : !in_fire & out_fire ? ST_EMPTY : ST_FULL;
                ld_out  = in_fire & out_fire;
                ld_skid = in_fire & !out_fire;
            end
            ST_SKID: begin
                nxt      = out_fire ? ST_FULL : ST_SKID;
                ld_out   = out_fire;
                use_skid = 1'b1;
            end
            default: nxt = ST_EMPTY;
        endcase
        if (flush) begin
            nxt     = ST_EMPTY;
            ld_out  = 1'b0;
            ld_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_dec   <= '0;
            out_pc_q  <= '0;
            out_imm_q <= '0;
            skid_dec  <= '0;
            skid_pc   <= '0;
            skid_imm  <= '0;
        end else begin
            if (ld_out) begin
                out_dec   <= use_skid ? skid_dec : in_dec;
                out_pc_q  <= use_skid ? skid_pc  : in_pc;
                out_imm_q <= use_skid ? skid_imm : d_imm;
            end
            if (ld_skid) begin
                skid_dec <= in_dec;
                skid_pc  <= in_pc;
                skid_imm <= d_imm;
            end
        end
    end

    assign out_pc      = out_pc_q;
    assign out_imm     = out_imm_q;
    assign out_class   = out_dec.cls;
    assign out_alu_op  = out_dec.alu_op;
    assign out_funct3  = out_dec.funct3;
    assign out_rs1     = out_dec.rs1;
    assign out_rs2     = out_dec.rs2;
    assign out_rd      = out_dec.rd;
    assign out_illegal = out_dec.illegal;

endmodule
